// File: rtl/pipe_skid_stage_pkg.sv
// Shared pipeline constants: occupancy encodings and default widths for the
// skid stage and its entry registers.
package pipe_skid_stage_pkg;

   localparam int DEF_DATA_W = 64;
   localparam int DEF_CNT_W  = 16;

   typedef logic [1:0] occ_t;

   localparam occ_t OCC_EMPTY = 2'd0;
   localparam occ_t OCC_ONE   = 2'd1;
   localparam occ_t OCC_FULL  = 2'd2;

endpackage

// File: rtl/pipe_skid_stage_entry.sv
// Single pipeline entry: payload plus valid flag, loaded or cleared on demand.
// Clearing restores the empty payload value so idle outputs are deterministic.
module pipe_entry
   import pipe_skid_stage_pkg::*;
#(
   parameter int                 DATA_W  = DEF_DATA_W,
   parameter logic [DATA_W-1:0]  CLR_VAL = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] data,
   output logic [DATA_W-1:0] payload,
   output logic              valid
);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         valid   <= 1'b0;
         payload <= CLR_VAL;
      end else if (load) begin
         valid   <= 1'b1;
         payload <= data;
      end
   end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer: main entry drives the output, skid entry absorbs one
// payload when downstream stalls so in_ready can come straight from a flop.
module pipe_skid_stage
   import pipe_skid_stage_pkg::*;
#(
   parameter int                 DATA_W  = DEF_DATA_W,
   parameter logic [DATA_W-1:0]  CLR_VAL = '0,
   parameter int                 CNT_W   = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   input  logic              flush,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic              main_valid, skid_valid;
   logic [DATA_W-1:0] main_payload, skid_payload;
   logic              main_load, main_clear, skid_load, skid_clear;
   logic [DATA_W-1:0] main_d;
   logic              accept, emit;

   assign in_ready  = ~skid_valid;
   assign out_valid = main_valid;
   assign out_data  = main_payload;

   assign accept = in_valid & ~skid_valid;
   assign emit   = main_valid & out_ready;

   always_comb begin
      main_load  = 1'b0;
      main_clear = 1'b0;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      main_d     = in_data;
      if (flush) begin
         main_clear = 1'b1;
         skid_clear = 1'b1;
      end else if (!main_valid) begin
         main_load = accept;
      end else if (!skid_valid) begin
         if (accept && emit) begin
            main_load = 1'b1;
         end else if (accept) begin
            skid_load = 1'b1;
         end else if (emit) begin
            main_clear = 1'b1;
         end
      end else if (emit) begin
         // both full: accept is impossible, skid drains into main
         main_load  = 1'b1;
         main_d     = skid_payload;
         skid_clear = 1'b1;
      end
   end

   pipe_entry #(.DATA_W(DATA_W), .CLR_VAL(CLR_VAL)) u_main (
      .clk     (clk),
      .reset   (reset),
      .load    (main_load),
      .clear   (main_clear),
      .data    (main_d),
      .payload (main_payload),
      .valid   (main_valid)
   );

   pipe_entry #(.DATA_W(DATA_W), .CLR_VAL(CLR_VAL)) u_skid (
      .clk     (clk),
      .reset   (reset),
      .load    (skid_load),
      .clear   (skid_clear),
      .data    (in_data),
      .payload (skid_payload),
      .valid   (skid_valid)
   );

   always_comb begin
      if (main_valid && skid_valid) begin
         occupancy = OCC_FULL;
      end else if (main_valid || skid_valid) begin
         occupancy = OCC_ONE;
      end else begin
         occupancy = OCC_EMPTY;
      end
   end

   // saturating stall counter; flush deliberately leaves it alone
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (main_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter DATA_W, default 64, SHALL set payload width (e.g. instruction + PC).
REQ-002 Parameter CLR_VAL, default all-zero DATA_W, SHALL be the payload value of an empty or flushed entry.
REQ-003 Parameter CNT_W, default 16, SHALL set the stall counter width.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream offers in_data.
REQ-007 in_data  input  DATA_W  upstream payload.
REQ-008 in_ready  output  1  stage can accept; SHALL be driven from a register, with no combinational path from out_ready.
REQ-009 out_valid  output  1  out_data is valid.
REQ-010 out_data  output  DATA_W  downstream payload; SHALL be driven from a register.
REQ-011 out_ready  input  1  downstream accepts.
REQ-012 flush  input  1  discard all held and incoming payloads.
REQ-013 occupancy  output  2  number of held entries, 0 to 2.
REQ-014 stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.

Function
REQ-015 An accept SHALL occur in a cycle with in_valid=1 and in_ready=1; an emit SHALL occur in a cycle with out_valid=1 and out_ready=1.
REQ-016 The stage SHALL hold at most two entries: a main entry that drives out_data and a skid entry.
REQ-017 When the stage is empty, an accepted payload SHALL appear on out_data with out_valid=1 in the next cycle (1-cycle latency).
REQ-018 If main is full and skid is empty, an accept with a simultaneous emit SHALL replace main with in_data.
REQ-019 If main is full and skid is empty, an accept without an emit SHALL load the skid entry, and in_ready SHALL be 0 from the next cycle.
REQ-020 If both entries are full, an emit SHALL move skid into main and empty skid, and in_ready SHALL be 1 from the next cycle.
REQ-021 If main is full, skid is empty, and an emit occurs with no accept, out_valid SHALL be 0 and out_data SHALL equal CLR_VAL in the next cycle.
REQ-022 in_ready SHALL equal NOT skid_valid; no payload SHALL ever be dropped or duplicated, and payload order SHALL be preserved.
REQ-023 While out_valid=1 and out_ready=0, out_data SHALL hold stable.
REQ-024 flush SHALL take priority over all other inputs: in the next cycle both entries SHALL be empty with payload CLR_VAL and in_ready=1, and any same-cycle accept SHALL be discarded.
REQ-025 occupancy SHALL equal main_valid + skid_valid and SHALL update in the same cycle as the entries.
REQ-026 stall_cnt SHALL increment in each cycle with out_valid=1 and out_ready=0, SHALL saturate at 2^CNT_W-1, and SHALL NOT be cleared by flush.

Reset
REQ-027 While reset=1, every state element SHALL load its reset value in the next cycle, taking priority over flush: out_valid=0, out_data=CLR_VAL, skid empty, in_ready=1, occupancy=0, stall_cnt=0.
REQ-028 Assertion of reset mid-transfer SHALL discard both entries without producing an emit.

Structure
REQ-029 The shared pipeline package SHALL hold the occupancy encoding constants (OCC_EMPTY=0, OCC_ONE=1, OCC_FULL=2) and the default DATA_W and CNT_W values.
REQ-030 A single-entry register sub-module, pipe_entry (payload, valid, load, clear), SHALL be instantiated twice, once for main and once for skid.
REQ-031 The flush, load and move decisions SHALL be made in one combinational control block in pipe_skid_stage.

Verification
REQ-032 Scenario 1: reset, then in_valid=1 with in_data=0x0000_3000_1234_5678 and out_ready=1 -> next cycle out_valid=1, out_data=0x..1234_5678, occupancy=1.
REQ-033 Scenario 2: out_ready=0, accept A then B -> in_ready=0 after B, occupancy=2, out_data=A held; then out_ready=1 for two cycles -> emits A then B, in_ready=1.
REQ-034 Scenario 3: both entries full and flush=1 together with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_data=CLR_VAL; the flushed payloads are never emitted.
REQ-035 Scenario 4: CNT_W=4, out_ready=0 for 20 cycles with main full -> stall_cnt=15 (saturated); a subsequent flush leaves it at 15; reset returns it to 0.
REQ-036 Scenario 5: random in_valid/out_ready over 10k cycles with a scoreboard -> the emitted sequence equals the accepted sequence minus flushed entries, and in_ready never depends combinationally on out_ready.
REQ-037 Scenario 6: reset asserted while occupancy=2 and out_ready=1 -> no emit occurs in the following cycle, and all reset values hold.
